sn_operand_deserializer: RTL and testbench

- Upstream front end of the stochastic add/multiply core.
- Receives two 9-bit bipolar probability operands as framed, LSB-first serial streams plus a mode bit.
- Validates framing and holds each accepted pair in a shadow buffer.
- Commits the pair to the core's operand registers only on the core's accumulation-epoch strobe, so operands never change mid-window.

---
 rtl/sn_operand_deserializer_pkg.sv | 14 +
 rtl/sn_operand_deserializer_if.sv | 33 +++
 rtl/sn_operand_deserializer_lane.sv | 23 ++
 rtl/sn_operand_deserializer.sv | 112 +++++++++++
 tb/tb_sn_operand_deserializer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sn_operand_deserializer_pkg.sv
// Shared constants and types for the stochastic add/multiply core front end.
package sn_pkg;
  localparam int SN_WIDTH       = 9;
  localparam int SN_WINDOW_LOG2 = 17;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GUARD = 2'd2
  } sn_state_e;
endpackage

// File: rtl/sn_operand_deserializer_if.sv
// Bus between the serial operand source / core and the operand deserializer.
interface sn_operand_deserializer_if
  import sn_pkg::*;
#(
  parameter int WIDTH = SN_WIDTH
);
  // Handshake: no back-pressure. frame_i is a one-cycle start strobe followed by
  // WIDTH LSB-first data cycles and a frame_i-low guard; epoch_i is a one-cycle
  // pulse, and a pair commits only when epoch_i and pending_o are both high at an edge.
  logic             frame_i;
  logic             mode_i;
  logic             din_a_i;
  logic             din_b_i;
  logic             epoch_i;
  logic [WIDTH-1:0] op_a_o;
  logic [WIDTH-1:0] op_b_o;
  logic             mode_o;
  logic             op_valid_o;
  logic             pending_o;
  logic             frame_err_o;
  logic             busy_o;
  logic [1:0]       state;

  modport master (
    output frame_i, mode_i, din_a_i, din_b_i, epoch_i,
    input  op_a_o, op_b_o, mode_o, op_valid_o, pending_o, frame_err_o, busy_o, state
  );

  modport slave (
    input  frame_i, mode_i, din_a_i, din_b_i, epoch_i,
    output op_a_o, op_b_o, mode_o, op_valid_o, pending_o, frame_err_o, busy_o, state
  );
endinterface

// File: rtl/sn_operand_deserializer_lane.sv
// LSB-first serial-to-parallel lane: each sample enters at the MSB and moves down.
module sn_serial_lane
  import sn_pkg::*;
#(
  parameter int WIDTH = SN_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clr) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {din, data[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/sn_operand_deserializer.sv
// Framed serial operand receiver with a shadow buffer that commits to the core
// operand registers only on the accumulation-epoch strobe.
module sn_operand_deserializer
  import sn_pkg::*;
#(
  parameter int WIDTH        = SN_WIDTH,
  parameter int GUARD_CYCLES = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  sn_operand_deserializer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + GUARD_CYCLES);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(WIDTH + GUARD_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_SHIFT = 2'(SHIFT);
  localparam logic [1:0] S_GUARD = 2'(GUARD);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             mode_tmp;
  logic [WIDTH-1:0] lane_a, lane_b;
  logic [WIDTH-1:0] shadow_a, shadow_b, op_a, op_b;
  logic             shadow_mode, mode_q, op_valid, pending, frame_err;
  logic             shift_en, accept, commit;

  assign shift_en = (state == S_SHIFT) && !bus.frame_i;
  assign accept   = (state == S_GUARD) && !bus.frame_i && (cnt == GUARD_LAST);
  assign commit   = bus.epoch_i && pending;

  sn_serial_lane #(.WIDTH(WIDTH)) u_lane_a (
    .clk(clk), .rst_n(rst_n), .clr(bus.frame_i), .shift_en(shift_en),
    .din(bus.din_a_i), .data(lane_a)
  );

  sn_serial_lane #(.WIDTH(WIDTH)) u_lane_b (
    .clk(clk), .rst_n(rst_n), .clr(bus.frame_i), .shift_en(shift_en),
    .din(bus.din_b_i), .data(lane_b)
  );

  // One counter spans data and guard cycles so it stops at GUARD_LAST and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mode_tmp <= 1'b0;
    end else if (bus.frame_i) begin
      state    <= S_SHIFT;
      cnt      <= '0;
      mode_tmp <= bus.mode_i;
    end else begin
      case (state)
        S_SHIFT: begin
          if (cnt == SHIFT_LAST) state <= S_GUARD;
          cnt <= cnt + CNT_W'(1);
        end
        S_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Commit reads the old shadow before an accept in the same cycle overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_a    <= '0;
      shadow_b    <= '0;
      shadow_mode <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      mode_q      <= 1'b0;
      op_valid    <= 1'b0;
      pending     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (commit) begin
        op_a     <= shadow_a;
        op_b     <= shadow_b;
        mode_q   <= shadow_mode;
        op_valid <= 1'b1;
      end
      if (accept) begin
        shadow_a    <= lane_a;
        shadow_b    <= lane_b;
        shadow_mode <= mode_tmp;
        frame_err   <= 1'b0;
      end else if (bus.frame_i && (state != S_IDLE)) begin
        frame_err <= 1'b1;
      end
      if (accept) pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end

  assign bus.op_a_o      = op_a;
  assign bus.op_b_o      = op_b;
  assign bus.mode_o      = mode_q;
  assign bus.op_valid_o  = op_valid;
  assign bus.pending_o   = pending;
  assign bus.frame_err_o = frame_err;
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.state       = state;
endmodule

// File: tb/tb_sn_operand_deserializer.sv
// Directed and randomized checks of the operand deserializer against a queue-based model.
module tb_sn_operand_deserializer;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sn_operand_deserializer_if #(.WIDTH(W)) bus ();

  sn_operand_deserializer #(.WIDTH(W), .GUARD_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  // Model: accepted-but-uncommitted frames {mode, b, a}; the newest one is what commits.
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_op_a, m_op_b;
  logic         m_mode, m_valid, m_err, m_busy;

  task automatic check_v(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_b(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_op_a = '0; m_op_b = '0; m_mode = 1'b0;
    m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_commit();
    if (exp_q.size() != 0) begin
      {m_mode, m_op_b, m_op_a} = exp_q[$];
      exp_q.delete();
      m_valid = 1'b1;
    end
  endtask

  task automatic check_all(string tag);
    check_v({tag, ".op_a"}, bus.op_a_o, m_op_a);
    check_v({tag, ".op_b"}, bus.op_b_o, m_op_b);
    check_b({tag, ".mode"}, bus.mode_o, m_mode);
    check_b({tag, ".op_valid"}, bus.op_valid_o, m_valid);
    check_b({tag, ".pending"}, bus.pending_o, exp_q.size() != 0);
    check_b({tag, ".frame_err"}, bus.frame_err_o, m_err);
    check_b({tag, ".busy"}, bus.busy_o, m_busy);
  endtask

  task automatic rand_din();
    bus.din_a_i = 1'($urandom);
    bus.din_b_i = 1'($urandom);
    bus.mode_i  = 1'($urandom);
  endtask

  task automatic start_cycle(logic mode);
    if (m_busy) m_err = 1'b1;
    rand_din();
    bus.frame_i = 1'b1;
    bus.mode_i  = mode;
    tick();
    bus.frame_i = 1'b0;
    m_busy = 1'b1;
    check_all("start");
  endtask

  task automatic send_frame(logic mode, logic [W-1:0] a, logic [W-1:0] b, logic epoch_at_guard);
    start_cycle(mode);
    for (int i = 0; i < W; i++) begin
      rand_din();
      bus.din_a_i = a[i];
      bus.din_b_i = b[i];
      tick();
    end
    check_all("last_bit");
    rand_din();
    bus.epoch_i = epoch_at_guard;
    tick();
    bus.epoch_i = 1'b0;
    if (epoch_at_guard) model_commit();
    exp_q.push_back({mode, b, a});
    m_err  = 1'b0;
    m_busy = 1'b0;
    check_all("accept");
  endtask

  task automatic abort_frame(int k);
    start_cycle(1'($urandom));
    for (int i = 0; i < k; i++) begin
      rand_din();
      tick();
    end
  endtask

  task automatic epoch_pulse();
    rand_din();
    bus.epoch_i = 1'b1;
    tick();
    bus.epoch_i = 1'b0;
    model_commit();
    check_all("epoch");
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      rand_din();
      tick();
    end
    check_all("idle");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.frame_i = 1'b0;
    bus.epoch_i = 1'b0;
    rand_din();
    model_reset();
    tick();
    tick();
    check_all("reset");
    rst_n = 1'b1;
    idle(2);

    epoch_pulse();
    check_b("idle_epoch.op_valid", bus.op_valid_o, 1'b0);

    send_frame(1'b1, 9'h1A5, 9'h0FF, 1'b0);
    idle(4);
    epoch_pulse();
    check_v("basic.op_a", bus.op_a_o, 9'h1A5);
    check_v("basic.op_b", bus.op_b_o, 9'h0FF);

    abort_frame(3);
    send_frame(1'b0, 9'h100, 9'h001, 1'b0);
    idle(3);
    epoch_pulse();
    check_v("ferr.op_a", bus.op_a_o, 9'h100);

    send_frame(1'b0, 9'h010, 9'($urandom), 1'b0);
    send_frame(1'b1, 9'h020, 9'($urandom), 1'b0);
    epoch_pulse();
    check_v("overwrite.op_a", bus.op_a_o, 9'h020);

    send_frame(1'b0, 9'h0C3, 9'h155, 1'b0);
    send_frame(1'b1, 9'h13C, 9'h0AA, 1'b1);
    check_v("simul.op_a", bus.op_a_o, 9'h0C3);
    epoch_pulse();
    check_v("simul2.op_a", bus.op_a_o, 9'h13C);

    abort_frame(9);
    send_frame(1'b1, 9'h1FF, 9'h000, 1'b0);
    epoch_pulse();

    abort_frame(4);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    tick();
    rst_n = 1'b1;
    idle(12);
    epoch_pulse();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0, 1: send_frame(1'($urandom), 9'($urandom), 9'($urandom), 1'($urandom));
        2: begin
          abort_frame(int'($urandom_range(0, 9)));
          send_frame(1'($urandom), 9'($urandom), 9'($urandom), 1'($urandom));
        end
        3: epoch_pulse();
        default: idle(int'($urandom_range(1, 3)));
      endcase
    end
    epoch_pulse();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
